alu16_issue_ctrl: RTL and testbench

- Command-side initiator for the team's 16-bit combinational ALU.
- Accepts encoded instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives A/B/ALU_Sel to an external ALU, captures ALU_Out/Zero, writes back, and returns a response over a second valid/ready handshake.
- Sits between the instruction source (testbench or future sequencer) and the ALU instance.

---
 rtl/alu16_pkg.sv | 52 +++++
 rtl/alu16_regfile.sv | 43 ++++
 rtl/alu16_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu16_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// Shared definitions for the 16-bit ALU issue controller slice.
// Holds the opcode map, the instruction field positions, the register
// file geometry and the controller state type.
package alu16_pkg;

  // ALU opcodes; the numeric value is driven straight onto alu_sel
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ASHL = 4'hA;
  localparam logic [3:0] OP_ASHR = 4'hB;
  localparam logic [3:0] OP_LDI  = 4'hC;

  // ALU select value presented while the ALU is bypassed by LDI
  localparam logic [3:0] SEL_BYPASS = 4'hF;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  // Register file geometry
  localparam int REG_ADDR_W = 3;
  localparam int REG_COUNT  = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // Anything above LDI has no meaning and is reported as an error
  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_LDI;
  endfunction

endpackage

// File: rtl/alu16_regfile.sv
// 8 x DATA_W register file for the issue controller.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset (clears all registers)
//   raddr_a/rdata_a   - asynchronous read port A
//   raddr_b/rdata_b   - asynchronous read port B
//   we/waddr/wdata    - synchronous write port
// Register 0 always reads as zero and ignores writes.
module alu16_regfile
  import alu16_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  // Storage: cleared on reset, written on we except for the hardwired r0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: r0 is forced to zero so it never depends on storage contents
  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
  end

endmodule

// File: rtl/alu16_issue_ctrl.sv
// Command-side initiator for the 16-bit combinational ALU.
// Accepts one instruction at a time, presents registered operands to the
// external ALU for one cycle, writes the result back to the register file
// and returns it over a response handshake.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_instr     - instruction handshake
//   alu_a/alu_b/alu_sel               - registered ALU operands and opcode
//   alu_out/alu_zero                  - ALU result and zero flag
//   rsp_valid/rsp_ready               - response handshake
//   rsp_data/rsp_zero/rsp_err         - written value, zero flag, illegal-op flag
module alu16_issue_ctrl
  import alu16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter bit LDI_SEXT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err
);

  state_t state_q, state_d;

  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [IMM_W-1:0]      imm_q;

  logic [3:0]            op_in;
  logic [DATA_W-1:0]     rf_rdata_a, rf_rdata_b;
  logic                  accept;
  logic                  illegal;
  logic [DATA_W-1:0]     imm_ext;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_zero;
  logic                  wb_en;

  assign op_in  = cmd_instr[OP_MSB:OP_LSB];
  assign accept = (state_q == IDLE) && cmd_valid;

  // Operands are read at accept time, before this instruction's own
  // writeback, which gives rd==rs hazards the pre-write value for free.
  alu16_regfile #(
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (cmd_instr[RS1_MSB:RS1_LSB]),
    .rdata_a (rf_rdata_a),
    .raddr_b (cmd_instr[RS2_MSB:RS2_LSB]),
    .rdata_b (rf_rdata_b),
    .we      (wb_en),
    .waddr   (rd_q),
    .wdata   (wb_data)
  );

  // Result selection for the EXEC cycle: LDI bypasses the ALU entirely
  always_comb begin
    illegal = is_illegal(op_q);
    if (LDI_SEXT) begin
      imm_ext = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    end else begin
      imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm_q};
    end
    if (op_q == OP_LDI) begin
      wb_data = imm_ext;
      wb_zero = (imm_ext == '0);
    end else begin
      wb_data = alu_out;
      wb_zero = alu_zero;
    end
    wb_en = (state_q == EXEC) && !illegal;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs: one instruction in flight at a time
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Instruction latch and ALU drive; held outside the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      rd_q  <= cmd_instr[RD_MSB:RD_LSB];
      imm_q <= cmd_instr[IMM_MSB:IMM_LSB];
      if (op_in == OP_LDI) begin
        alu_a   <= '0;
        alu_b   <= '0;
        alu_sel <= SEL_BYPASS;
      end else begin
        alu_a   <= rf_rdata_a;
        alu_b   <= rf_rdata_b;
        alu_sel <= op_in;
      end
    end
  end

  // Response registers: loaded once at the end of EXEC, held through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_data <= illegal ? '0 : wb_data;
      rsp_zero <= illegal ? 1'b0 : wb_zero;
      rsp_err  <= illegal;
    end
  end

endmodule

// File: tb/tb_alu16_issue_ctrl.sv
// Self-checking bench for alu16_issue_ctrl.
// Supplies a behavioural 16-bit ALU, keeps an array model of the register
// file and checks every response, latency, stall and reset behaviour.
module tb_alu16_issue_ctrl;

  localparam bit SEXT = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_instr;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_rf [8];

  alu16_issue_ctrl #(
    .DATA_W   (16),
    .LDI_SEXT (SEXT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_instr (cmd_instr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Golden model of the team ALU
  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa;
    sa = a;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a | b);
      4'h6: return ~(a & b);
      4'h7: return ~(a ^ b);
      4'h8: return a << 1;
      4'h9: return a >> 1;
      4'hA: return a << 1;
      4'hB: return 16'(sa >>> 1);
      default: return 16'h0000;
    endcase
  endfunction

  // The bench plays the role of the external ALU
  assign alu_out  = ref_alu(alu_sel, alu_a, alu_b);
  assign alu_zero = (alu_out == 16'h0000);

  function automatic logic [15:0] mk(input logic [3:0] op, input int rd, input int rs1, input int rs2);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] mk_ldi(input int rd, input logic [5:0] imm);
    return {4'hC, 3'(rd), 3'b000, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one instruction, checks operands, latency and response, stalls the
  // response for 'hold' cycles, completes the handshake and updates the model.
  task automatic applyStimulus(input logic [15:0] instr, input int hold);
    logic [3:0]  op;
    int          rd, rs1, rs2;
    logic [5:0]  imm;
    logic [15:0] exp_a, exp_b, exp_data;
    logic [3:0]  exp_sel;
    logic        exp_zero, exp_err;
    int          guard;

    op  = instr[15:12];
    rd  = int'(instr[11:9]);
    rs1 = int'(instr[8:6]);
    rs2 = int'(instr[5:3]);
    imm = instr[5:0];

    exp_a   = model_rf[rs1];
    exp_b   = model_rf[rs2];
    exp_sel = op;
    exp_err = 1'b0;
    if (op > 4'hC) begin
      exp_err  = 1'b1;
      exp_data = 16'h0000;
      exp_zero = 1'b0;
    end else if (op == 4'hC) begin
      exp_data = SEXT ? 16'(signed'(imm)) : {10'b0, imm};
      exp_zero = (exp_data == 16'h0000);
      exp_a    = 16'h0000;
      exp_b    = 16'h0000;
      exp_sel  = 4'hF;
    end else begin
      exp_data = ref_alu(op, exp_a, exp_b);
      exp_zero = (exp_data == 16'h0000);
    end

    cmd_instr = instr;
    cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_wait", 16'(cmd_ready), 16'h1);

    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_instr = 16'($urandom);
    rsp_ready = (hold == 0);
    checkOutput("exec_cmd_ready", 16'(cmd_ready), 16'h0);
    checkOutput("exec_rsp_valid", 16'(rsp_valid), 16'h0);
    if (!exp_err) begin
      checkOutput("exec_alu_a", alu_a, exp_a);
      checkOutput("exec_alu_b", alu_b, exp_b);
      checkOutput("exec_alu_sel", 16'(alu_sel), 16'(exp_sel));
    end

    @(posedge clk); #1;
    checkOutput("latency_rsp_valid", 16'(rsp_valid), 16'h1);
    checkOutput("rsp_data", rsp_data, exp_data);
    checkOutput("rsp_zero", 16'(rsp_zero), 16'(exp_zero));
    checkOutput("rsp_err", 16'(rsp_err), 16'(exp_err));

    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_instr = mk(4'h0, 7, 1, 2);
      @(posedge clk); #1;
      checkOutput("stall_rsp_valid", 16'(rsp_valid), 16'h1);
      checkOutput("stall_rsp_data", rsp_data, exp_data);
      checkOutput("stall_rsp_zero", 16'(rsp_zero), 16'(exp_zero));
      checkOutput("stall_cmd_ready", 16'(cmd_ready), 16'h0);
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("post_hs_rsp_valid", 16'(rsp_valid), 16'h0);
    checkOutput("post_hs_cmd_ready", 16'(cmd_ready), 16'h1);
    cmd_valid = 1'b0;

    if (!exp_err && rd != 0) begin
      model_rf[rd] = exp_data;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_instr = 16'h0000;
    rsp_ready = 1'b0;

    #2;
    checkOutput("reset_cmd_ready", 16'(cmd_ready), 16'h1);
    checkOutput("reset_rsp_valid", 16'(rsp_valid), 16'h0);
    checkOutput("reset_alu_a", alu_a, 16'h0000);
    checkOutput("reset_alu_sel", 16'(alu_sel), 16'h0);
    checkOutput("reset_rsp_data", rsp_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic LDI/ADD");
    applyStimulus(mk_ldi(1, 6'd5), 0);
    applyStimulus(mk_ldi(2, 6'd3), 0);
    applyStimulus(16'h0650, 0);
    checkOutput("add_r3_value", model_rf[3], 16'h0008);

    $display("[TB] SUB to zero with backpressure");
    applyStimulus(mk(4'h1, 4, 1, 1), 5);

    $display("[TB] sign-extended LDI and wrap");
    applyStimulus(mk_ldi(1, 6'h3F), 0);
    applyStimulus(mk(4'h0, 5, 1, 1), 1);
    applyStimulus(mk_ldi(7, 6'h00), 0);

    $display("[TB] ASHR after shift chain");
    applyStimulus(mk_ldi(1, 6'd1), 0);
    for (int i = 0; i < 15; i++) applyStimulus(mk(4'h8, 1, 1, 0), 0);
    applyStimulus(mk(4'hB, 6, 1, 0), 0);

    $display("[TB] illegal op leaves rd unchanged");
    applyStimulus(mk_ldi(2, 6'd9), 0);
    applyStimulus(mk(4'hE, 2, 1, 1), 2);
    applyStimulus(mk(4'h0, 3, 2, 0), 0);

    $display("[TB] random instructions");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] reset during EXEC");
    applyStimulus(mk_ldi(1, 6'd4), 0);
    applyStimulus(mk_ldi(2, 6'd6), 0);
    cmd_instr = mk(4'h0, 3, 1, 2);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("pre_rst_cmd_ready", 16'(cmd_ready), 16'h0);
    rst = 1'b1;
    #1;
    checkOutput("rst_cmd_ready", 16'(cmd_ready), 16'h1);
    checkOutput("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    checkOutput("rst_alu_a", alu_a, 16'h0000);
    checkOutput("rst_alu_b", alu_b, 16'h0000);
    checkOutput("rst_alu_sel", 16'(alu_sel), 16'h0);
    checkOutput("rst_rsp_data", rsp_data, 16'h0000);
    checkOutput("rst_rsp_err", 16'(rsp_err), 16'h0);
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("post_rst_no_rsp", 16'(rsp_valid), 16'h0);
    applyStimulus(mk(4'h0, 3, 1, 2), 0);
    checkOutput("post_rst_add_value", model_rf[3], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
